// File: rtl/branch_stall_unit.sv
// -----------------------------------------------------------------------------
// branch_stall_unit
//
// Purpose:
//   ID-stage hazard detector for the 5-stage MIPS pipeline. It keeps a private
//   two-slot shadow of the destination registers in flight (EX and MEM) and
//   holds the ID stage until a branch operand, or an operand that depends on a
//   load, can be forwarded. The branch forwarding network only consumes the
//   EX/MEM and MEM/WB results, so this unit is its producer-side counterpart.
//
// Ports:
//   clock         in   pipeline clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   id_valid      in   IF/ID holds a real instruction
//   id_op         in   [5:0] opcode in IF/ID
//   id_rs         in   [4:0] rs field in IF/ID
//   id_rt         in   [4:0] rt field in IF/ID
//   id_rd         in   [4:0] resolved destination of the ID instruction
//   id_regwrite   in   ID instruction writes a register
//   id_memread    in   ID instruction is a load
//   flush         in   redirect: squash the ID instruction this cycle
//   stall         out  ID held this cycle
//   pc_write      out  PC write enable (~stall)
//   ifid_write    out  IF/ID write enable (~stall)
//   idex_bubble   out  insert a NOP into ID/EX (stall | flush)
//   stall_cycles  out  [CNT_W-1:0] saturating count of stalled cycles
//                      (present only when BRANCH_STALL_STATS_EN is defined)
//
// Build option:
//   BRANCH_STALL_STATS_EN - when defined, adds the stall_cycles port and its
//   saturating counter. All other behaviour is identical either way.
// -----------------------------------------------------------------------------
module branch_stall_unit #(
  parameter logic [5:0] BEQ_OP = 6'b000100,
  parameter logic [5:0] BNE_OP = 6'b000101,
  parameter int         CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble
`ifdef BRANCH_STALL_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  localparam logic [5:0] J_OP   = 6'b000010;
  localparam logic [5:0] JAL_OP = 6'b000011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STALL1 = 2'd1,
    STALL2 = 2'd2
  } state_e;

  // Shadow slots: valid bits are control (reset), rd/ld are data (no reset).
  logic       ex_v_q,  ex_v_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic       ex_ld_q, ex_ld_d;
  logic       mem_v_q,  mem_v_d;
  logic [4:0] mem_rd_q, mem_rd_d;
  logic       mem_ld_q, mem_ld_d;

  state_e     state_q, state_d;
  state_e     cur_state;

  // Decode of the ID instruction
  logic       is_branch;
  logic       is_jump;
  logic       uses_src;
  logic       rs_live;
  logic       rt_live;

  // Slot matches and hazard classes
  logic       ex_hit;
  logic       mem_hit;
  logic       haz_one;
  logic       haz_two;
  logic       stall_int;

  // ---------------------------------------------------------------------------
  // ID decode and operand matching against the shadow slots
  // ---------------------------------------------------------------------------
  always_comb begin
    is_branch = id_valid && ((id_op == BEQ_OP) || (id_op == BNE_OP));
    is_jump   = (id_op == J_OP) || (id_op == JAL_OP);
    // Jumps carry no register operands in rs/rt, so their fields are ignored.
    uses_src  = id_valid && (is_branch || !is_jump);
    // Register 0 is hard-wired and is never a real dependency.
    rs_live   = uses_src && (id_rs != 5'd0);
    rt_live   = uses_src && (id_rt != 5'd0);

    ex_hit  = ex_v_q  && ((rs_live && (ex_rd_q  == id_rs)) ||
                          (rt_live && (ex_rd_q  == id_rt)));
    mem_hit = mem_v_q && ((rs_live && (mem_rd_q == id_rs)) ||
                          (rt_live && (mem_rd_q == id_rt)));
  end

  // ---------------------------------------------------------------------------
  // Hazard classification. The EX slot is the youngest producer, so when it
  // matches it alone decides; the MEM slot only matters when EX misses.
  //   branch + EX ALU result  : 1 cycle (then EX/MEM forward covers it)
  //   branch + EX load        : 2 cycles (wait for MEM/WB)
  //   branch + MEM load       : 1 cycle
  //   other  + EX load        : 1 cycle (classic load-use)
  // ---------------------------------------------------------------------------
  always_comb begin
    haz_two = is_branch && ex_hit && ex_ld_q;
    haz_one = (is_branch && ex_hit && !ex_ld_q) ||
              (is_branch && !ex_hit && mem_hit && mem_ld_q) ||
              (!is_branch && ex_hit && ex_ld_q);
    // A redirect squashes the ID instruction, so there is nothing to hold.
    stall_int = (haz_one || haz_two) && !flush;
  end

  always_comb begin
    stall       = stall_int;
    pc_write    = !stall_int;
    ifid_write  = !stall_int;
    idex_bubble = stall_int || flush;
  end

  // ---------------------------------------------------------------------------
  // Shadow pipeline next-state: MEM takes EX, EX takes the ID instruction only
  // when it actually advances and produces a non-zero destination.
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_v_d   = id_valid && !stall_int && !flush &&
               id_regwrite && (id_rd != 5'd0);
    ex_rd_d  = id_rd;
    ex_ld_d  = id_memread;
    mem_v_d  = ex_v_q;
    mem_rd_d = ex_rd_q;
    mem_ld_d = ex_ld_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_v_q  <= 1'b0;
      mem_v_q <= 1'b0;
    end else begin
      ex_v_q  <= ex_v_d;
      mem_v_q <= mem_v_d;
    end
  end

  always_ff @(posedge clock) begin
    ex_rd_q  <= ex_rd_d;
    ex_ld_q  <= ex_ld_d;
    mem_rd_q <= mem_rd_d;
    mem_ld_q <= mem_ld_d;
  end

  // ---------------------------------------------------------------------------
  // Hazard tracking state. cur_state is the state the pipeline is in during
  // this cycle: a held stall continues from state_q, otherwise a fresh hazard
  // enters STALL1/STALL2 directly, so it agrees with stall in the same cycle.
  // A squashed or empty ID slot always reads as IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_state = IDLE;
    if (flush || !id_valid) begin
      cur_state = IDLE;
    end else if (state_q != IDLE) begin
      cur_state = state_q;
    end else if (haz_two) begin
      cur_state = STALL2;
    end else if (haz_one) begin
      cur_state = STALL1;
    end
  end

  always_comb begin
    state_d = IDLE;
    case (cur_state)
      STALL2:  state_d = STALL1;
      STALL1:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef BRANCH_STALL_STATS_EN
  // ---------------------------------------------------------------------------
  // Stall statistics: saturating count of edges taken while stalled.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_int && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

`ifndef SYNTHESIS
  // While the ID slot keeps the same occupancy, the slot-derived stall and the
  // tracking state must tell the same story.
  property p_stall_tracks_state;
    @(posedge clock) disable iff (!reset_n)
      (id_valid == $past(id_valid)) |-> (stall == (cur_state != IDLE));
  endproperty
  a_stall_tracks_state: assert property (p_stall_tracks_state);
`endif

endmodule

// File: tb/tb_branch_stall_unit.sv
module tb_branch_stall_unit;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2b;

  logic       clock;
  logic       reset_n;
  logic       id_valid;
  logic [5:0] id_op;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_regwrite, id_memread, flush;
  logic       stall, pc_write, ifid_write, idex_bubble;
`ifdef BRANCH_STALL_STATS_EN
  logic [15:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  branch_stall_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .id_valid    (id_valid),
    .id_op       (id_op),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .stall       (stall),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .idex_bubble (idex_bubble)
`ifdef BRANCH_STALL_STATS_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit       v;
    bit [5:0] op;
    bit [4:0] rs, rt, rd;
    bit       rw, mr, fl;
    bit       es;
  } vec_t;

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       ld;
  } slot_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit v, bit [5:0] op, int rs, int rt, int rd,
                              bit rw, bit mr, bit fl, bit es);
    vec_t r;
    r.v = v; r.op = op; r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
    r.rw = rw; r.mr = mr; r.fl = fl; r.es = es;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(bit v, bit [5:0] op, int rs, int rt, int rd,
                       bit rw, bit mr, bit fl);
    id_valid = v; id_op = op; id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    id_regwrite = rw; id_memread = mr; flush = fl;
  endtask

  // One cycle: drive at the falling edge, check combinational outputs 1ns later.
  task automatic cycle_chk(string name, bit v, bit [5:0] op, int rs, int rt,
                           int rd, bit rw, bit mr, bit fl, bit es);
    @(negedge clock);
    drive(v, op, rs, rt, rd, rw, mr, fl);
    #1;
    check(name, {28'd0, stall, pc_write, ifid_write, idex_bubble},
          {28'd0, es, ~es, ~es, es | fl});
  endtask

  task automatic nops(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      drive(0, OP_R, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // Reference model: youngest matching producer decides; a stall is needed
  // while the producer is younger than the age at which its value can reach
  // the consumer (branch: ALU result at age 2, load at age 3; other: load at 2).
  slot_t hist[1:2];
  int    exp_cnt;

  function automatic bit model_stall(bit v, bit [5:0] op, bit [4:0] rs,
                                     bit [4:0] rt, bit fl);
    bit br, uses;
    int need;
    br   = v && (op == OP_BEQ || op == OP_BNE);
    uses = v && (br || !(op == OP_J || op == OP_JAL));
    if (!uses || fl) return 1'b0;
    for (int age = 1; age <= 2; age++) begin
      if (hist[age].v && ((rs != 0 && hist[age].rd == rs) ||
                          (rt != 0 && hist[age].rd == rt))) begin
        if (br) need = hist[age].ld ? 3 : 2;
        else    need = hist[age].ld ? 2 : 1;
        return (age < need);
      end
    end
    return 1'b0;
  endfunction

  initial begin
    bit       rv, rrw, rmr, rfl, es, prev_es;
    bit [5:0] rop;
    int       rrs, rrt, rrd;

    drive(0, OP_R, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", {28'd0, stall, pc_write, ifid_write, idex_bubble},
          32'b0110);
`ifdef BRANCH_STALL_STATS_EN
    check("reset_stall_cycles", 32'(stall_cycles), 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;

    // lw $8 then beq $8,$9: two stall cycles
    cycle_chk("t1_lw",   1, OP_LW,  1, 8, 8, 1, 1, 0, 0);
    cycle_chk("t1_beq0", 1, OP_BEQ, 8, 9, 0, 0, 0, 0, 1);
    cycle_chk("t1_beq1", 1, OP_BEQ, 8, 9, 0, 0, 0, 0, 1);
    cycle_chk("t1_beq2", 1, OP_BEQ, 8, 9, 0, 0, 0, 0, 0);
`ifdef BRANCH_STALL_STATS_EN
    check("t1_stall_cycles", 32'(stall_cycles), 32'd2);
`endif
    nops(2);

    // Table of back-to-back sequences, each drained by two empty cycles.
    vecs.push_back(mk(1, OP_R,   1, 2, 8, 1, 0, 0, 0)); // add $8
    vecs.push_back(mk(1, OP_BEQ, 8, 0, 0, 0, 0, 0, 1)); // beq $8,$0
    vecs.push_back(mk(1, OP_BEQ, 8, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, OP_LW,  1, 8, 8, 1, 1, 0, 0)); // lw $8
    vecs.push_back(mk(1, OP_R,   8, 9, 10, 1, 0, 0, 1)); // add $10,$8,$9
    vecs.push_back(mk(1, OP_R,   8, 9, 10, 1, 0, 0, 0));
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, OP_LW,  1, 8, 8, 1, 1, 0, 0)); // lw $8
    vecs.push_back(mk(1, OP_R,   1, 2, 11, 1, 0, 0, 0)); // independent
    vecs.push_back(mk(1, OP_R,   8, 9, 10, 1, 0, 0, 0)); // no load-use stall
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, OP_R,   1, 2, 0, 1, 0, 0, 0)); // add $0
    vecs.push_back(mk(1, OP_BEQ, 0, 0, 0, 0, 0, 0, 0)); // beq $0,$0
    vecs.push_back(mk(1, OP_BEQ, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, OP_LW,  1, 8, 8, 1, 1, 0, 0)); // lw $8
    vecs.push_back(mk(1, OP_J,   8, 8, 0, 0, 0, 0, 0)); // jump ignores fields
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, OP_LW,  1, 8, 8, 1, 1, 0, 0)); // lw $8
    vecs.push_back(mk(0, OP_BEQ, 8, 9, 0, 0, 0, 0, 0)); // invalid ID slot
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, OP_LW,  1, 8, 8, 1, 1, 0, 0)); // lw $8
    vecs.push_back(mk(1, OP_R,   1, 2, 8, 1, 0, 0, 0)); // add $8 (newer)
    vecs.push_back(mk(1, OP_BEQ, 8, 3, 0, 0, 0, 0, 1)); // EX add governs
    vecs.push_back(mk(1, OP_BEQ, 8, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, OP_R,   1, 2, 9, 1, 0, 0, 0)); // add $9
    vecs.push_back(mk(1, OP_BNE, 5, 9, 0, 0, 0, 0, 1)); // bne $5,$9
    vecs.push_back(mk(1, OP_BNE, 5, 9, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, OP_R,   1, 2, 8, 1, 0, 0, 0)); // add $8
    vecs.push_back(mk(1, OP_BEQ, 8, 9, 0, 0, 0, 1, 0)); // flushed
    vecs.push_back(mk(1, OP_BEQ, 8, 9, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      cycle_chk($sformatf("vec%0d", i), vecs[i].v, vecs[i].op, vecs[i].rs,
                vecs[i].rt, vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].fl,
                vecs[i].es);
    end

    // Flush on the first cycle of a two-cycle stall
    cycle_chk("t5_lw",    1, OP_LW,  1, 8, 8, 1, 1, 0, 0);
    cycle_chk("t5_flush", 1, OP_BEQ, 8, 9, 0, 0, 0, 1, 0);
    // lw is now in MEM; the re-presented beq sees only the one-cycle case
    cycle_chk("t5_after", 1, OP_BEQ, 8, 9, 0, 0, 0, 0, 1);
    cycle_chk("t5_done",  1, OP_BEQ, 8, 9, 0, 0, 0, 0, 0);
    nops(2);

    // Asynchronous reset in the middle of a stall
    cycle_chk("t6_lw",  1, OP_LW,  1, 8, 8, 1, 1, 0, 0);
    cycle_chk("t6_beq", 1, OP_BEQ, 8, 9, 0, 0, 0, 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_reset", {28'd0, stall, pc_write, ifid_write, idex_bubble},
          32'b0110);
`ifdef BRANCH_STALL_STATS_EN
    check("t6_stall_cycles", 32'(stall_cycles), 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("t6_release", {31'd0, stall}, 32'd0);
    cycle_chk("t6_beq_again", 1, OP_BEQ, 8, 9, 0, 0, 0, 0, 0);
    nops(2);

    // Randomised traffic against the reference model. Counter starts from 0
    // at the last reset; t6 and its drain cycles produced no stalls.
    hist[1] = '{0, 0, 0};
    hist[2] = '{0, 0, 0};
    exp_cnt = 0;
    prev_es = 1'b0;
    rv = 0; rop = OP_R; rrs = 0; rrt = 0; rrd = 0; rrw = 0; rmr = 0;
    for (int i = 0; i < 3000; i++) begin
      // A stalled IF/ID register holds its instruction.
      if (!prev_es) begin
        rv  = ($urandom_range(0, 9) != 0);
        case ($urandom_range(0, 6))
          0:       rop = OP_LW;
          1:       rop = OP_R;
          2:       rop = OP_BEQ;
          3:       rop = OP_BNE;
          4:       rop = OP_J;
          5:       rop = OP_JAL;
          default: rop = OP_SW;
        endcase
        rrs = $urandom_range(0, 3);
        rrt = $urandom_range(0, 3);
        rrd = $urandom_range(0, 3);
        rmr = (rop == OP_LW);
        rrw = (rop == OP_LW) || (rop == OP_JAL) ||
              ((rop == OP_R) && ($urandom_range(0, 3) != 0));
      end
      rfl = ($urandom_range(0, 9) == 0);
      @(negedge clock);
      drive(rv, rop, rrs, rrt, rrd, rrw, rmr, rfl);
      es = model_stall(rv, rop, 5'(rrs), 5'(rrt), rfl);
      #1;
      check("rand", {28'd0, stall, pc_write, ifid_write, idex_bubble},
            {28'd0, es, ~es, ~es, es | rfl});
      hist[2] = hist[1];
      hist[1] = '{rv && !es && !rfl && rrw && (rrd != 0), 5'(rrd), rmr};
      if (es) exp_cnt++;
      prev_es = es;
    end
    @(negedge clock);
    drive(0, OP_R, 0, 0, 0, 0, 0, 0);
`ifdef BRANCH_STALL_STATS_EN
    #1;
    check("rand_stall_cycles", 32'(stall_cycles), 32'(exp_cnt));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_stall_unit.md
Name: branch_stall_unit

Overview:
- ID-stage hazard producer for the MIPS pipeline; the counterpart of the branch forwarding logic, which only consumes EX/MEM and MEM/WB results.
- Keeps a private two-slot shadow pipeline (EX, MEM) of in-flight destination registers.
- Stalls the ID stage until a branch or load-dependent operand can be forwarded.
- Drives the PC/IF-ID write enables and the ID/EX bubble insertion.

Parameters:
- BEQ_OP, 6'b000100, opcode of BEQ
- BNE_OP, 6'b000101, opcode of BNE
- CNT_W, 16, width of the stall statistics counter

Ports:
- clock  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_op  in  6  opcode in IF/ID
- id_rs  in  5  rs field in IF/ID
- id_rt  in  5  rt field in IF/ID
- id_rd  in  5  resolved destination of the ID instruction (rd or rt, after RegDst)
- id_regwrite  in  1  ID instruction writes a register
- id_memread  in  1  ID instruction is a load
- flush  in  1  redirect: squash the ID instruction this cycle
- stall  out  1  ID held this cycle
- pc_write  out  1  equals ~stall
- ifid_write  out  1  equals ~stall
- idex_bubble  out  1  insert NOP into ID/EX (stall | flush)
- stall_cycles  out  CNT_W  total stalled cycles; only with the optional feature

Behaviour:
- Shadow slots: ex_{v,rd,ld} and mem_{v,rd,ld}.
- Reset (async, reset_n=0): all slot valids 0; stall=0, pc_write=1, ifid_write=1, idex_bubble=0; state IDLE; stall_cycles=0.
- Each rising edge:
  - MEM slot <= EX slot.
  - EX slot <= ID instruction if id_valid & ~stall & ~flush, otherwise a bubble (v=0).
  - ex_v is set only when id_regwrite=1 and id_rd!=0.
- Match definition:
  - Slot S matches rs if S.v & S.rd==id_rs & id_rs!=0; same rule for rt.
  - Branch = id_valid & (id_op==BEQ_OP | id_op==BNE_OP).
  - Branch uses rs and rt. A non-branch uses rs and rt only if its op is not a jump (op 6'b000010/000011).
- Combinational stall; no added latency, evaluated from the current slots:
  - Branch & EX match, non-load: stall (1 cycle; next cycle the EX/MEM forward covers it).
  - Branch & EX match, load: stall (2 cycles).
  - Branch & MEM match, load: stall (1 cycle).
  - Non-branch & EX match, load: stall (1 cycle, load-use).
  - All other cases: no stall; forwarding covers them.
- State machine (tracking and verification aid; stall stays derived from the slots):
  - IDLE -> STALL1 on a 1-cycle hazard; IDLE -> STALL2 on a 2-cycle hazard.
  - STALL2 -> STALL1; STALL1 -> IDLE.
  - Required: stall==(state!=IDLE) whenever id_valid is stable. An assertion checks this.
- flush has priority over stall:
  - If flush=1: stall=0, idex_bubble=1, state -> IDLE, EX slot receives a bubble.
  - flush takes effect even mid-stall (e.g. in STALL2).
- id_valid=0: no stall, bubble shifts into EX.
- Reset asserted mid-stall: outputs return to reset values immediately (asynchronous); no stall after release until a new hazard.
- Register 0 never matches.
- A match in both EX and MEM slots: the EX slot governs.

Optional Feature:
- Macro BRANCH_STALL_STATS_EN.
- Defined:
  - stall_cycles increments by 1 on every edge where stall=1 and flush=0.
  - It saturates at all-ones and is cleared by reset.
- Undefined:
  - Port stall_cycles is absent and the counter logic is not generated.
  - All other behaviour is identical.

Test Plan:
1. lw $8 issued, then beq $8,$9 in ID next cycle: stall=1 for 2 cycles, pc_write=0, idex_bubble=1 each cycle, then stall=0; stall_cycles=2.
2. add $8 issued, then beq $8,$0: stall=1 for exactly 1 cycle, then released.
3. lw $8, then add $10,$8,$9: stall 1 cycle. With an independent instruction between lw and add: no stall.
4. add $0 (rd=0), then beq $0,$0: no stall ever.
5. lw $8, beq $8 stalled in STALL2, flush=1 on the first stall cycle: stall=0 the same cycle, idex_bubble=1, state IDLE next edge.
6. Hazard pending, reset_n pulsed low mid-cycle: stall drops to 0 asynchronously, slots cleared, stall_cycles=0; a subsequent beq on the same register does not stall.
